mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter sitting directly downstream of the processor data bus, on the 0xf0000000 MMIO window. It replaces the behavioural print/halt model with synthesizable logic. It accepts byte writes into a TX FIFO, serializes them 8N1 on txd, answers TX-available polls, and raises a halt pulse. Data memory decoding (addresses below 0x08000000) is outside this block.

---
 rtl/mmio_pkg.sv | 13 +
 rtl/mmio_uart_tx_sync_fifo.sv | 41 ++++
 rtl/mmio_uart_tx.sv | 127 ++++++++++++
 tb/tb_mmio_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO offsets, TX FSM state encodings and defaults for the UART slice
package mmio_pkg;
  localparam logic [3:0] OFF_HALT = 4'h0;
  localparam logic [3:0] OFF_TXD = 4'h4;
  localparam logic [3:0] OFF_STAT = 4'h8;
  localparam int DEF_CLKS_PER_BIT = 868;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_START = 2'd1,
    S_DATA = 2'd2,
    S_STOP = 2'd3
  } tx_state_t;
endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, show-ahead read data
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic w_push;
  logic w_pop;
  assign o_count = r_wr - r_rd;
  assign o_full = o_count[AW];
  assign o_empty = o_count == '0;
  assign o_data = r_mem[r_rd[AW-1:0]];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  // pointer update; the extra wrap bit tells full apart from empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
  // storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO UART transmitter with halt strobe; status register enabled by MMIO_UART_STATUS_EN
import mmio_pkg::*;
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_AW = 4,
  parameter logic [31:0] BASE = 32'hf0000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        txd,
  output logic        halt
);
  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);
  tx_state_t r_state;
  logic [15:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic r_txd;
  logic r_halt;
  logic r_ready;
  logic [31:0] r_rdata;
  logic w_sel;
  logic w_wr;
  logic w_rd;
  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_bit_end;
  logic w_unused;
  logic [3:0] w_off;
  logic [7:0] w_fifo_data;
  logic [FIFO_AW:0] w_count;
  logic [31:0] w_stat;
  assign w_sel = mem_oe && (mem_addr[31:28] == BASE[31:28]);
  assign w_off = mem_addr[3:0];
  assign w_wr = w_sel && (mem_we != 4'd0);
  assign w_rd = w_sel && (mem_we == 4'd0);
  assign w_push_req = w_wr && (w_off == OFF_TXD) && mem_we[0];
  assign w_bit_end = r_cnt == 16'd0;
  // Popping at the end of a stop bit chains frames with no idle gap
  assign w_pop = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_bit_end));
  assign w_unused = &{1'b0, mem_addr[27:4], mem_wdata[31:8], w_count};
  sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push_req),
    .i_data(mem_wdata[7:0]),
    .i_pop(w_pop),
    .o_data(w_fifo_data),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );
`ifdef MMIO_UART_STATUS_EN
  logic r_ovf;
  // sticky overflow: set by a dropped push, cleared by any status write
  always_ff @(posedge clk) begin
    if (!rst) r_ovf <= 1'b0;
    else if (w_wr && w_off == OFF_STAT) r_ovf <= 1'b0;
    else if (w_push_req && w_full) r_ovf <= 1'b1;
  end
  assign w_stat = {22'd0, r_ovf, r_state != S_IDLE, w_empty, 7'(w_count)};
`else
  assign w_stat = '0;
`endif
  // bus side: registered read response and one-cycle halt strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_halt <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_halt <= w_wr && (w_off == OFF_HALT);
      r_ready <= w_rd;
      r_rdata <= !w_rd ? '0 : w_off == OFF_TXD ? {31'd0, !w_full} : w_off == OFF_STAT ? w_stat : '0;
    end
  end
  // 8N1 serializer: start, 8 data bits LSB first, stop; txd is registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_txd <= 1'b1;
    end else if (w_pop) begin
      r_state <= S_START;
      r_shift <= w_fifo_data;
      r_cnt <= CNT_MAX;
      r_txd <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) r_cnt <= r_cnt - 16'd1;
      else begin
        r_cnt <= CNT_MAX;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_bit <= '0;
            r_txd <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_txd <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd <= r_shift[1];
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign txd = r_txd;
  assign halt = r_halt;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench; serial frames decoded from txd and compared with queued bytes
module tb_mmio_uart_tx;
  localparam int CPB = 4;
  localparam logic [31:0] BASE = 32'hf0000000;
`ifdef MMIO_UART_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif
  logic clk;
  logic rst;
  logic [31:0] mem_addr;
  logic mem_oe;
  logic [31:0] mem_wdata;
  logic [3:0] mem_we;
  logic [31:0] mem_rdata;
  logic mem_ready;
  logic txd;
  logic halt;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nfr = 0;
  int prev_cyc = 0;
  int start_cyc = 0;
  int occ;
  int lowcnt;
  bit popped;
  bit mon_en = 1'b1;
  bit mon_busy = 1'b0;
  bit b2b = 1'b0;
  logic [7:0] sb[$];

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .BASE(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_oe(mem_oe),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .txd(txd),
    .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] frame_bits(input logic [7:0] b);
    logic [63:0] f;
    int slot;
    f = '0;
    for (int i = 0; i < 10*CPB; i++) begin
      slot = i / CPB;
      f[i] = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot-1];
    end
    return f;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    mem_oe = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    mem_we = we;
    @(negedge clk);
    mem_oe = 1'b0;
    mem_we = 4'd0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    mem_oe = 1'b1;
    mem_addr = a;
    mem_we = 4'd0;
    @(negedge clk);
    mem_oe = 1'b0;
    chk({t, "_rdy"}, mem_ready, 1);
    chk({t, "_data"}, mem_rdata, e);
    @(negedge clk);
    chk({t, "_rdy_drop"}, mem_ready, 0);
    chk({t, "_data_clr"}, mem_rdata, 0);
  endtask

  task automatic drain(input int maxc);
    int k;
    for (k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_busy) break;
    end
    chk("drain_in_time", k < maxc, 1);
  endtask

  // line monitor: decode each frame sample by sample and compare with the scoreboard head
  initial begin
    logic [63:0] obs;
    logic [7:0] eb;
    bit abort;
    forever begin
      @(negedge clk);
      if (mon_en && rst && txd == 1'b0) begin
        mon_busy = 1'b1;
        start_cyc = cyc;
        abort = 1'b0;
        chk("frame_expected", sb.size() != 0, 1);
        eb = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        if (b2b && nfr > 0) chk("frame_gap", start_cyc - prev_cyc, 10*CPB);
        prev_cyc = start_cyc;
        nfr++;
        obs = '0;
        obs[0] = txd;
        for (int i = 1; i < 10*CPB; i++) begin
          @(negedge clk);
          if (!mon_en) begin
            abort = 1'b1;
            break;
          end
          obs[i] = txd;
        end
        if (!abort) chk($sformatf("frame_%02h", eb), obs, frame_bits(eb));
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b0;
    mem_oe = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_we = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", mem_ready, 0);
    chk("rst_halt", halt, 0);
    chk("rst_rdata", mem_rdata, 0);
    rst = 1'b1;
    rd(BASE + 32'h8, STAT_EN ? 32'h80 : 32'h0, "stat_rst");
    rd(BASE + 32'h4, 32'h1, "poll_empty");
    // back-to-back reads give back-to-back ready cycles
    mem_oe = 1'b1;
    mem_addr = BASE + 32'h4;
    mem_we = 4'd0;
    @(negedge clk);
    chk("b2b_rdy1", mem_ready, 1);
    chk("b2b_data1", mem_rdata, 1);
    mem_addr = BASE + 32'hc;
    @(negedge clk);
    mem_oe = 1'b0;
    chk("b2b_rdy2", mem_ready, 1);
    chk("b2b_data2", mem_rdata, 0);
    @(negedge clk);
    chk("b2b_rdy_drop", mem_ready, 0);
    // outside the window: no response
    mem_oe = 1'b1;
    mem_addr = 32'h00000004;
    @(negedge clk);
    mem_oe = 1'b0;
    chk("unsel_rdy", mem_ready, 0);
    // halt; upper offset bits ignored
    wr(32'hf1230000, 32'h0, 4'hf);
    chk("halt_hi", halt, 1);
    chk("halt_no_rdy", mem_ready, 0);
    @(negedge clk);
    chk("halt_one_cycle", halt, 0);
    // writes that must not start a frame
    wr(BASE + 32'h4, 32'h55, 4'b0010);
    wr(BASE + 32'hc, 32'h66, 4'hf);
    repeat (6) @(negedge clk);
    chk("ignored_txd", txd, 1);
    // single byte
    sb.push_back(8'h41);
    wr(BASE + 32'h4, 32'hffffff41, 4'b0001);
    @(negedge clk);
    chk("start_latency", txd, 0);
    drain(200);
    chk("idle_txd", txd, 1);
    repeat (2) @(negedge clk);
    rd(BASE + 32'h8, STAT_EN ? 32'h80 : 32'h0, "stat_idle");
    rd(BASE + 32'h4, 32'h1, "poll_idle");
    // overflow burst: model occupancy, fullness judged before the same-cycle pop
    nfr = 0;
    b2b = 1'b1;
    occ = 0;
    popped = 1'b0;
    for (int j = 0; j < 18; j++) begin
      if (occ < 16) begin
        sb.push_back(8'(j));
        occ++;
      end
      if (!popped && j >= 1) begin
        occ--;
        popped = 1'b1;
      end
      wr(BASE + 32'h4, 32'(j), 4'b0001);
    end
    rd(BASE + 32'h4, 32'h0, "poll_full");
    rd(BASE + 32'h8, STAT_EN ? 32'h310 : 32'h0, "stat_ovf");
    drain(1000);
    b2b = 1'b0;
    chk("frame_count", nfr, 17);
    wr(BASE + 32'h8, 32'h0, 4'hf);
    rd(BASE + 32'h8, STAT_EN ? 32'h80 : 32'h0, "stat_clr");
    // reset during data bit 3 with two bytes still queued
    sb.push_back(8'ha5);
    sb.push_back(8'h3c);
    sb.push_back(8'h0f);
    wr(BASE + 32'h4, 32'ha5, 4'b0001);
    wr(BASE + 32'h4, 32'h3c, 4'b0001);
    wr(BASE + 32'h4, 32'h0f, 4'b0001);
    repeat (16) @(negedge clk);
    chk("pre_rst_bit3", txd, 0);
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", txd, 1);
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    mon_en = 1'b1;
    lowcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (!txd) lowcnt++;
    end
    chk("no_frames_after_rst", lowcnt, 0);
    rd(BASE + 32'h8, STAT_EN ? 32'h80 : 32'h0, "stat_after_rst");
    rd(BASE + 32'h4, 32'h1, "poll_after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
